rr_arbiter_4to1: RTL

RR_ARBITER_4TO1 -- requirements
Module: rr_arbiter_4to1

---
 rtl/rr_arbiter_4to1.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rr_arbiter_4to1.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_4to1
// Purpose  : Round-robin arbiter that drains four input FIFOs into one
//            output FIFO, in bursts of up to QUANTUM words per grant.
//            Pop-to-push latency is a fixed two cycles.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_4to1 #(
   parameter int LINE_SIZE = 12,
   parameter int QUANTUM   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           empty_signal,
   input  logic [3:0]           almost_empty_signal,
   input  logic [LINE_SIZE-1:0] data_in0,
   input  logic [LINE_SIZE-1:0] data_in1,
   input  logic [LINE_SIZE-1:0] data_in2,
   input  logic [LINE_SIZE-1:0] data_in3,
   input  logic                 almost_full_signal,
   output logic [3:0]           pop_signal,
   output logic                 push_signal,
   output logic [LINE_SIZE-1:0] data_out,
   output logic [1:0]           grant_id,
   output logic                 busy
);

   typedef enum logic [0:0] {
      ARB   = 1'b0,
      SERVE = 1'b1
   } state_t;

   localparam logic [3:0] QUANTUM_C = 4'(QUANTUM);

   state_t               state_q, state_d;
   logic [1:0]           rr_ptr_q, rr_ptr_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [1:0]           grant_q, grant_d;
   logic [3:0]           pop_q, pop_d;
   // vld_q marks the cycle in which the FIFO read data of a pop is valid;
   // vid_q remembers which input that pop addressed.
   logic                 vld_q, vld_d;
   logic [1:0]           vid_q, vid_d;
   logic                 push_q, push_d;
   logic [LINE_SIZE-1:0] dout_q, dout_d;

   logic                 found;
   logic [1:0]           cand;
   logic                 pop_ok;
   logic                 burst_done;
   logic [LINE_SIZE-1:0] rd_data;

   // Select the read data of the input whose pop is now returning data.
   always_comb begin
      rd_data = data_in0;
      case (vid_q)
         2'd0:    rd_data = data_in0;
         2'd1:    rd_data = data_in1;
         2'd2:    rd_data = data_in2;
         default: rd_data = data_in3;
      endcase
   end

   // Next-state logic: arbitration, burst control and the push pipeline.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = cnt_q;
      grant_d    = grant_q;
      pop_d      = '0;
      found      = 1'b0;
      cand       = rr_ptr_q;
      pop_ok     = 1'b0;
      burst_done = 1'b0;

      // The pipeline is never stalled: every popped word is pushed exactly
      // two cycles after its pop, regardless of back-pressure.
      vld_d  = |pop_q;
      vid_d  = grant_q;
      push_d = vld_q;
      dout_d = vld_q ? rd_data : dout_q;

      case (state_q)
         ARB: begin
            if (!almost_full_signal && (empty_signal != 4'hF)) begin
               for (int k = 0; k < 4; k++) begin
                  cand = rr_ptr_q + 2'(k);
                  if (!found && !empty_signal[cand]) begin
                     found   = 1'b1;
                     grant_d = cand;
                  end
               end
               cnt_d   = '0;
               state_d = SERVE;
            end
         end
         SERVE: begin
            // A pop in flight on a FIFO holding at most one word may be the
            // last one, so the next pop waits for the refreshed empty flag.
            pop_ok = !empty_signal[grant_q] && !almost_full_signal &&
                     (cnt_q < QUANTUM_C) &&
                     !(pop_q[grant_q] && almost_empty_signal[grant_q]);
            burst_done = (cnt_q == QUANTUM_C) ||
                         (empty_signal[grant_q] && !pop_q[grant_q]);
            if (pop_ok) begin
               pop_d[grant_q] = 1'b1;
               cnt_d          = cnt_q + 4'd1;
            end
            if (burst_done) begin
               state_d  = ARB;
               rr_ptr_d = grant_q + 2'd1;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ARB;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
         pop_q    <= '0;
         vld_q    <= 1'b0;
         vid_q    <= '0;
         push_q   <= 1'b0;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         pop_q    <= pop_d;
         vld_q    <= vld_d;
         vid_q    <= vid_d;
         push_q   <= push_d;
         dout_q   <= dout_d;
      end
   end

   assign pop_signal  = pop_q;
   assign push_signal = push_q;
   assign data_out    = dout_q;
   assign grant_id    = grant_q;
   assign busy        = (state_q == SERVE) | (|pop_q) | vld_q;

endmodule
`default_nettype wire
